// File: rtl/spiflash_pkg.sv
// Shared types and command codes for the burst SPI NOR flash model.
package spiflash_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADR, READ, PROG, STAT, IGNORE} statetype;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PROG = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;

  // State that follows a fully received command byte. WREN/WRDI carry no
  // payload, so they fall into IGNORE like unknown opcodes.
  function automatic statetype cmd_decode(input logic [7:0] c);
    case (c)
      CMD_READ, CMD_PROG: cmd_decode = ADR;
      CMD_RDSR:           cmd_decode = STAT;
      default:            cmd_decode = IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/spiflash_edgesync.sv
// Brings SCK and CS into the PCLK domain and turns SCK transitions into
// single-cycle sample / shift strobes for the selected CPOL/CPHA mode.
module spiflash_edgesync
  import spiflash_pkg::*;
#(
  parameter int CLK_POL = 0,
  parameter int CLK_PHA = 0
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic SCK,
  input  logic CS,
  output logic SampleEdge,
  output logic ShiftEdge,
  output logic CSSync
);

  // sck_q[1:0] is the 2-flop synchroniser, sck_q[2] the previous synced value.
  logic [2:0] sck_q;
  logic [1:0] cs_q;
  logic       rise, fall;

  // Synchroniser chains; SCK resets to its idle level so no false edge appears.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sck_q <= {3{CLK_POL != 0}};
      cs_q  <= 2'b11;
    end else begin
      sck_q <= {sck_q[1:0], SCK};
      cs_q  <= {cs_q[0], CS};
    end
  end

  assign rise       = sck_q[1] & ~sck_q[2];
  assign fall       = ~sck_q[1] & sck_q[2];
  assign SampleEdge = (CLK_POL == CLK_PHA) ? rise : fall;
  assign ShiftEdge  = (CLK_POL == CLK_PHA) ? fall : rise;
  // CS has the same synchroniser depth as SCK so simultaneous pin changes stay aligned.
  assign CSSync     = cs_q[1];

endmodule

// File: rtl/spiflash_burst.sv
// Burst SPI NOR flash model: command / multi-byte address / data framing,
// auto-incrementing read and program, status register, all four SPI modes.
// Build option SPIFLASH_WREN_EN: when defined, programming needs a prior
// WREN (8'h06) and WRDI (8'h04) clears the latch; when undefined the write
// enable latch reads as 1 and programming always lands.
module spiflash_burst
  import spiflash_pkg::*;
#(
  parameter int CLK_POL    = 0,
  parameter int CLK_PHA    = 0,
  parameter int ADDR_BYTES = 3,
  parameter int DEPTH      = 64
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic SCK,
  input  logic CS,
  input  logic MOSI,
  output logic MISO,
  output logic Busy
);

  localparam int AW       = $clog2(DEPTH);
  localparam int ADR_BITS = ADDR_BYTES * 8;
  localparam int ACW      = $clog2(ADR_BITS);
  localparam logic [ACW-1:0] ADR_LAST = ACW'(ADR_BITS - 1);

  statetype       state_q, state_d;
  logic           samp_edge, shft_edge, cs_s;
  logic [1:0]     settle_q;
  logic           armed_q;
  logic [2:0]     bit_q;
  logic [ACW-1:0] acnt_q;
  logic [7:0]     rx_q, tx_q;
  logic [AW-1:0]  addr_q;
  logic           rd_q, miso_q, wrote_q, wel;
  logic [7:0]     mem_q [DEPTH];
  logic           samp, shft, cmd_done, adr_done, prog_byte, tx_step, mem_we;
  logic [7:0]     rx_byte, tx_load;

  spiflash_edgesync #(.CLK_POL(CLK_POL), .CLK_PHA(CLK_PHA)) u_sync (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .SCK        (SCK),
    .CS         (CS),
    .SampleEdge (samp_edge),
    .ShiftEdge  (shft_edge),
    .CSSync     (cs_s)
  );

  // Byte as it will look once the current MOSI bit is shifted in.
  assign rx_byte = {rx_q[6:0], MOSI};
  assign MISO    = miso_q;

`ifdef SPIFLASH_WREN_EN
  logic wel_q;
  // Write enable latch; a completed program frame consumes it on CS rise.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                   wel_q <= 1'b0;
    else if (cs_s && state_q != IDLE && wrote_q)    wel_q <= 1'b0;
    else if (cmd_done && rx_byte == CMD_WREN)       wel_q <= 1'b1;
    else if (cmd_done && rx_byte == CMD_WRDI)       wel_q <= 1'b0;
  end
  assign wel = wel_q;
`else
  assign wel = 1'b1;
`endif

  // Hold off until the CS synchroniser reflects the pin, and only accept a
  // new frame once CS has been seen high, so a frame cut by reset is ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && cs_s) armed_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; CS high returns to IDLE from anywhere and beats any edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (settle_q[1] && !cs_s) state_d = armed_q ? CMD : IGNORE;
      CMD:     if (cmd_done) state_d = cmd_decode(rx_byte);
      ADR:     if (adr_done) state_d = rd_q ? READ : PROG;
      default: ;
    endcase
    if (state_q != IDLE && cs_s) state_d = IDLE;
  end

  // Per-state strobes; edges coinciding with CS high are dropped.
  always_comb begin
    samp      = samp_edge & ~cs_s;
    shft      = shft_edge & ~cs_s;
    cmd_done  = (state_q == CMD)  && samp && (bit_q == 3'd7);
    adr_done  = (state_q == ADR)  && samp && (acnt_q == ADR_LAST);
    prog_byte = (state_q == PROG) && samp && (bit_q == 3'd7);
    mem_we    = prog_byte && wel;
    tx_step   = ((state_q == READ) || (state_q == STAT)) && shft;
    tx_load   = (state_q == READ) ? mem_q[addr_q] : {6'b0, wel, 1'b0};
    Busy      = (state_q != IDLE);
  end

  // Shift registers, bit/address counters and the MISO flop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bit_q   <= '0;
      acnt_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      wrote_q <= 1'b0;
    end else if (state_q == IDLE) begin
      // Any partially assembled byte is forgotten between frames.
      bit_q   <= '0;
      acnt_q  <= '0;
      miso_q  <= 1'b0;
      wrote_q <= 1'b0;
    end else begin
      if ((state_q == CMD || state_q == PROG) && samp) begin
        rx_q  <= rx_byte;
        bit_q <= bit_q + 3'd1;
      end
      if (cmd_done) begin
        addr_q <= '0;
        rd_q   <= (rx_byte == CMD_READ);
      end
      if (state_q == ADR && samp) begin
        // Only the low AW bits survive, which keeps the address modulo DEPTH.
        addr_q <= {addr_q[AW-2:0], MOSI};
        acnt_q <= adr_done ? '0 : acnt_q + 1'b1;
      end
      if (mem_we) begin
        addr_q  <= addr_q + 1'b1;
        wrote_q <= 1'b1;
      end
      if (tx_step) begin
        // Bit 0 of each byte loads fresh data and presents its MSB at once.
        if (bit_q == 3'd0) begin
          miso_q <= tx_load[7];
          tx_q   <= {tx_load[6:0], 1'b0};
        end else begin
          miso_q <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end
        bit_q <= bit_q + 3'd1;
        if (state_q == READ && bit_q == 3'd7) addr_q <= addr_q + 1'b1;
      end
      if (state_q != READ && state_q != STAT) miso_q <= 1'b0;
    end
  end

  // Storage array, erased to 8'hFF by reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= 8'hFF;
    end else if (mem_we) begin
      mem_q[addr_q] <= rx_byte;
    end
  end

endmodule
